spi_flash_responder: RTL and testbench

SPI-flash responder on the far end of the programmer's SPI link. It oversamples the programmer's SCK, CS_N and MOSI on the system clock and answers a subset of the standard serial-flash command set from a small internal byte memory. It is used as an on-chip loopback target and as a bench model for the programmer master. Only SPI mode 0 is supported.

---
 rtl/spi_flash_pkg.sv | 29 ++
 rtl/spi_sync_edge.sv | 36 +++
 rtl/spi_flash_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared opcodes, responder FSM states and status-register bit positions
// for the SPI flash responder.
package spi_flash_pkg;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_PP   = 8'h02;
  localparam logic [7:0] CMD_WREN = 8'h06;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_RDID = 8'h9F;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_TX     = 3'd3,
    ST_RX     = 3'd4,
    ST_IGNORE = 3'd5
  } resp_state_t;

  localparam int STATUS_WIP = 0;
  localparam int STATUS_WEL = 1;

  // Synthetic read data used when no memory array is built.
  function automatic logic [7:0] read_pattern(input logic [7:0] addr);
    return addr ^ 8'hA5;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for one asynchronous SPI pin, plus a delayed copy
// that yields single-cycle rise and fall pulses in the clk_in1 domain.
module spi_sync_edge
  import spi_flash_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_in1,
  input  logic reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_dly;

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
      r_dly  <= RESET_VAL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_dly  <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_dly;
  assign o_fall  = ~r_sync & r_dly;

endmodule

// File: rtl/spi_flash_responder.sv
// Mode-0 SPI serial-flash responder (RDID, RDSR, READ, optional WREN/WRDI/PP).
// Define SPI_RESP_PROGRAM_EN to build the byte memory and program/busy logic.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
  parameter int          MEM_AW      = 8,
  parameter int          BUSY_CYCLES = 64
) (
  input  logic       clk_in1,
  input  logic       reset,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic       cmd_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] status
);

  logic w_sck_rise;
  logic w_sck_fall;
  logic w_cs_n;
  logic w_cs_rise;
  logic w_mosi;
  logic w_unused_sck_level;
  logic w_unused_cs_fall;
  logic w_unused_mosi_rise;
  logic w_unused_mosi_fall;
  logic w_unused_busy;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .i_async (spi_sck),
    .o_level (w_unused_sck_level),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .i_async (spi_cs_n),
    .o_level (w_cs_n),
    .o_rise  (w_cs_rise),
    .o_fall  (w_unused_cs_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .i_async (spi_mosi),
    .o_level (w_mosi),
    .o_rise  (w_unused_mosi_rise),
    .o_fall  (w_unused_mosi_fall)
  );

  assign w_unused_busy = (BUSY_CYCLES != 0);

  resp_state_t       r_state;
  logic [4:0]        r_bit_cnt;
  logic [7:0]        r_shift_in;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_tx_shift;
  logic [2:0]        r_tx_bit;
  logic [1:0]        r_id_idx;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_cmd_valid;
  logic [7:0]        r_cmd_code;

  logic [7:0]  w_in_byte;
  logic        w_cmd_done;
  logic        w_wel;
  logic        w_wip;
  logic [7:0]  w_status;
  logic [7:0]  w_mem_rdata;
  logic [7:0]  w_tx_byte;
  resp_state_t w_decode_state;

  assign w_in_byte  = {r_shift_in[6:0], w_mosi};
  assign w_cmd_done = (r_state == ST_CMD) && !w_cs_n && w_sck_rise &&
                      (r_bit_cnt == 5'd7);

  always_comb begin
    w_status             = 8'h00;
    w_status[STATUS_WEL] = w_wel;
    w_status[STATUS_WIP] = w_wip;
  end

  // While a program is in progress only status polling is honoured.
  always_comb begin
    w_decode_state = ST_IGNORE;
    if (w_wip) begin
      if (w_in_byte == CMD_RDSR) w_decode_state = ST_TX;
    end else begin
      case (w_in_byte)
        CMD_RDID, CMD_RDSR: w_decode_state = ST_TX;
        CMD_READ:           w_decode_state = ST_ADDR;
`ifdef SPI_RESP_PROGRAM_EN
        CMD_PP:             if (w_wel) w_decode_state = ST_ADDR;
`endif
        default:            w_decode_state = ST_IGNORE;
      endcase
    end
  end

  always_comb begin
    w_tx_byte = 8'h00;
    case (r_cmd_code)
      CMD_RDID: begin
        case (r_id_idx)
          2'd0:    w_tx_byte = JEDEC_ID[23:16];
          2'd1:    w_tx_byte = JEDEC_ID[15:8];
          2'd2:    w_tx_byte = JEDEC_ID[7:0];
          default: w_tx_byte = 8'h00;
        endcase
      end
      CMD_RDSR: w_tx_byte = w_status;
      CMD_READ: w_tx_byte = w_mem_rdata;
      default:  w_tx_byte = 8'h00;
    endcase
  end

  // Response bytes are fetched at each byte boundary so RDSR sees live status.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_shift_in  <= 8'h00;
      r_addr      <= '0;
      r_tx_shift  <= 8'h00;
      r_tx_bit    <= 3'd7;
      r_id_idx    <= 2'd0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= 8'h00;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_cs_n) begin
        r_state    <= ST_IDLE;
        r_bit_cnt  <= 5'd0;
        r_shift_in <= 8'h00;
        r_tx_shift <= 8'h00;
        r_tx_bit   <= 3'd7;
        r_miso     <= 1'b0;
        r_miso_oe  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state   <= ST_CMD;
            r_bit_cnt <= 5'd0;
          end
          ST_CMD: begin
            if (w_sck_rise) begin
              r_shift_in <= w_in_byte;
              if (w_cmd_done) begin
                r_bit_cnt   <= 5'd0;
                r_cmd_valid <= 1'b1;
                r_cmd_code  <= w_in_byte;
                r_state     <= w_decode_state;
                r_tx_bit    <= 3'd7;
                r_id_idx    <= 2'd0;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_ADDR: begin
            if (w_sck_rise) begin
              r_addr <= MEM_AW'({r_addr, w_mosi});
              if (r_bit_cnt == 5'd23) begin
                r_bit_cnt <= 5'd0;
                r_state   <= (r_cmd_code == CMD_READ) ? ST_TX : ST_RX;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          ST_TX: begin
            if (w_sck_fall) begin
              r_miso_oe <= 1'b1;
              r_tx_bit  <= r_tx_bit - 3'd1;
              if (r_tx_bit == 3'd7) begin
                r_miso     <= w_tx_byte[7];
                r_tx_shift <= {w_tx_byte[6:0], 1'b0};
                if (r_cmd_code == CMD_RDID && r_id_idx != 2'd3)
                  r_id_idx <= r_id_idx + 2'd1;
                if (r_cmd_code == CMD_READ)
                  r_addr <= r_addr + 1'b1;
              end else begin
                r_miso     <= r_tx_shift[7];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end
          ST_RX: begin
            if (w_sck_rise) begin
              r_shift_in <= w_in_byte;
              if (r_bit_cnt[2:0] == 3'd7) begin
                r_bit_cnt <= 5'd0;
                r_addr    <= r_addr + 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef SPI_RESP_PROGRAM_EN
  localparam int DEPTH  = 2 ** MEM_AW;
  localparam int BUSY_W = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES + 1) : 1;

  logic [7:0]        r_mem [DEPTH] = '{default: 8'hFF};
  logic              r_wel;
  logic              r_wip;
  logic              r_rx_wrote;
  logic [BUSY_W-1:0] r_busy_cnt;
  logic              w_rx_byte_done;

  assign w_rx_byte_done = (r_state == ST_RX) && !w_cs_n && w_sck_rise &&
                          (r_bit_cnt[2:0] == 3'd7);

  // Programming can only clear bits, as on real NOR flash.
  always_ff @(posedge clk_in1) begin
    if (w_rx_byte_done) r_mem[r_addr] <= r_mem[r_addr] & w_in_byte;
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_wel      <= 1'b0;
      r_wip      <= 1'b0;
      r_rx_wrote <= 1'b0;
      r_busy_cnt <= '0;
    end else begin
      if (w_cs_rise && r_state == ST_RX && r_rx_wrote) begin
        r_wip      <= (BUSY_CYCLES != 0);
        r_wel      <= 1'b0;
        r_busy_cnt <= BUSY_W'(BUSY_CYCLES);
      end else if (r_wip) begin
        if (r_busy_cnt <= BUSY_W'(1)) begin
          r_wip      <= 1'b0;
          r_busy_cnt <= '0;
        end else begin
          r_busy_cnt <= r_busy_cnt - BUSY_W'(1);
        end
      end
      if (w_cmd_done && !r_wip) begin
        if (w_in_byte == CMD_WREN)      r_wel <= 1'b1;
        else if (w_in_byte == CMD_WRDI) r_wel <= 1'b0;
      end
      if (w_rx_byte_done)            r_rx_wrote <= 1'b1;
      else if (r_state == ST_IDLE)   r_rx_wrote <= 1'b0;
    end
  end

  assign w_wel       = r_wel;
  assign w_wip       = r_wip;
  assign w_mem_rdata = r_mem[r_addr];
`else
  assign w_wel       = 1'b0;
  assign w_wip       = 1'b0;
  assign w_mem_rdata = read_pattern(8'(r_addr));
`endif

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign cmd_valid   = r_cmd_valid;
  assign cmd_code    = r_cmd_code;
  assign status      = w_status;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: the stimulus acts as a mode-0 SPI
// master and queues expected MISO bytes and command codes for two monitors.
module tb_spi_flash_responder;

  logic       clk_in1 = 1'b0;
  logic       reset;
  logic       spi_sck;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic       cmd_valid;
  logic [7:0] cmd_code;
  logic [7:0] status;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic [7:0] val;
    bit         chk;
  } expByte_t;

  expByte_t   byteQ[$];
  logic [7:0] cmdQ[$];

  // Expected values that depend on whether the program feature is built.
`ifdef SPI_RESP_PROGRAM_EN
  localparam logic [7:0] EXP_RD_FE = 8'hFF, EXP_RD_FF = 8'hFF, EXP_RD_00 = 8'hFF, EXP_RD_01 = 8'hFF;
  localparam logic [7:0] EXP_ST_WEL = 8'h02, EXP_ST_B0 = 8'h01, EXP_ST_B1 = 8'h01;
  localparam logic [7:0] EXP_RD_10 = 8'h3C, EXP_RD_11 = 8'hC3, EXP_RD_20 = 8'hFF, EXP_RD_40 = 8'hFF;
`else
  localparam logic [7:0] EXP_RD_FE = 8'h5B, EXP_RD_FF = 8'h5A, EXP_RD_00 = 8'hA5, EXP_RD_01 = 8'hA4;
  localparam logic [7:0] EXP_ST_WEL = 8'h00, EXP_ST_B0 = 8'h00, EXP_ST_B1 = 8'h00;
  localparam logic [7:0] EXP_RD_10 = 8'hB5, EXP_RD_11 = 8'hB4, EXP_RD_20 = 8'h85, EXP_RD_40 = 8'hE5;
`endif

  spi_flash_responder #(
    .JEDEC_ID    (24'hEF4016),
    .MEM_AW      (8),
    .BUSY_CYCLES (160)
  ) dut (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .status      (status)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // SCK runs at clk_in1/8: four cycles low with MOSI set, four cycles high.
  task automatic applyStimulus(input logic [7:0] b, input int nBits);
    for (int i = 7; i >= 8 - nBits; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = b[i];
      repeat (4) @(negedge clk_in1);
      spi_sck = 1'b1;
      repeat (4) @(negedge clk_in1);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic [7:0] expv, input bit chk);
    expByte_t e;
    e.val = expv;
    e.chk = chk;
    byteQ.push_back(e);
    applyStimulus(b, 8);
  endtask

  task automatic sendCmd(input logic [7:0] c);
    cmdQ.push_back(c);
    sendByte(c, 8'h00, 1'b0);
  endtask

  task automatic sendAddr(input logic [23:0] a);
    sendByte(a[23:16], 8'h00, 1'b0);
    sendByte(a[15:8], 8'h00, 1'b0);
    sendByte(a[7:0], 8'h00, 1'b0);
  endtask

  task automatic expectByte(input logic [7:0] v);
    sendByte(8'h00, v, 1'b1);
  endtask

  task automatic csLow();
    @(negedge clk_in1);
    spi_cs_n = 1'b0;
    repeat (8) @(negedge clk_in1);
  endtask

  task automatic csHigh();
    spi_sck = 1'b0;
    repeat (8) @(negedge clk_in1);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk_in1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_miso"}, {31'd0, spi_miso}, 32'd0);
    checkOutput({tag, "_miso_oe"}, {31'd0, spi_miso_oe}, 32'd0);
    checkOutput({tag, "_cmd_valid"}, {31'd0, cmd_valid}, 32'd0);
    checkOutput({tag, "_cmd_code"}, {24'd0, cmd_code}, 32'd0);
    checkOutput({tag, "_status"}, {24'd0, status}, 32'd0);
  endtask

  // Master-side receiver: assembles MISO at each SCK rise, discards partial bytes.
  initial begin : monitorMiso
    int         bitCnt;
    int         byteNum;
    logic [7:0] sh;
    logic       oeAll;
    expByte_t   e;
    bitCnt  = 0;
    byteNum = 0;
    sh      = 8'h00;
    oeAll   = 1'b1;
    forever begin
      @(posedge spi_sck or posedge spi_cs_n);
      if (spi_cs_n) begin
        bitCnt = 0;
        oeAll  = 1'b1;
      end else begin
        sh     = {sh[6:0], spi_miso};
        oeAll  = oeAll & spi_miso_oe;
        bitCnt = bitCnt + 1;
        if (bitCnt == 8) begin
          if (byteQ.size() == 0) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL miso_byte_%0d: got unexpected byte %02h, expected none", byteNum, sh);
          end else begin
            e = byteQ.pop_front();
            if (e.chk) begin
              vecCount++;
              if (sh !== e.val || oeAll !== 1'b1) begin
                missCount++;
                $display("[TB] FAIL miso_byte_%0d: got %02h oe=%0b, expected %02h oe=1",
                         byteNum, sh, oeAll, e.val);
              end
            end
          end
          byteNum = byteNum + 1;
          bitCnt  = 0;
          oeAll   = 1'b1;
        end
      end
    end
  end

  initial begin : monitorCmd
    logic [7:0] expCmd;
    forever begin
      @(negedge clk_in1);
      if (cmd_valid === 1'b1) begin
        if (cmdQ.size() == 0) begin
          vecCount++;
          missCount++;
          $display("[TB] FAIL cmd_valid: got pulse with code %02h, expected none", cmd_code);
        end else begin
          expCmd = cmdQ.pop_front();
          checkOutput("cmd_code", {24'd0, cmd_code}, {24'd0, expCmd});
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    reset    = 1'b1;
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk_in1);
    checkResetOutputs("reset");
    reset = 1'b0;
    repeat (4) @(negedge clk_in1);

    csLow();
    sendCmd(8'h9F);
    expectByte(8'hEF); expectByte(8'h40); expectByte(8'h16); expectByte(8'h00);
    csHigh();

    csLow();
    sendCmd(8'h03);
    sendAddr(24'h0000FE);
    expectByte(EXP_RD_FE); expectByte(EXP_RD_FF); expectByte(EXP_RD_00); expectByte(EXP_RD_01);
    csHigh();

    csLow(); sendCmd(8'h06); csHigh();
    csLow(); sendCmd(8'h05); expectByte(EXP_ST_WEL); expectByte(EXP_ST_WEL); csHigh();

    csLow();
    sendCmd(8'h02);
    sendAddr(24'h000010);
    sendByte(8'h3C, 8'h00, 1'b0);
    sendByte(8'hC3, 8'h00, 1'b0);
    csHigh();

    csLow();
    sendCmd(8'h05);
    expectByte(EXP_ST_B0); expectByte(EXP_ST_B1); expectByte(8'h00); expectByte(8'h00);
    csHigh();

    csLow(); sendCmd(8'h03); sendAddr(24'h000010); expectByte(EXP_RD_10); expectByte(EXP_RD_11); csHigh();

    csLow(); sendCmd(8'h02); sendAddr(24'h000020); sendByte(8'h00, 8'h00, 1'b0); csHigh();
    csLow(); sendCmd(8'h03); sendAddr(24'h000020); expectByte(EXP_RD_20); csHigh();

    csLow(); applyStimulus(8'h9F, 5); csHigh();
    csLow(); sendCmd(8'h05); expectByte(8'h00); expectByte(8'h00); csHigh();

    csLow();
    sendCmd(8'h03);
    sendAddr(24'h000040);
    expectByte(EXP_RD_40);
    applyStimulus(8'h00, 4);
    reset = 1'b1;
    #1;
    checkResetOutputs("midreset");
    spi_cs_n = 1'b1;
    spi_sck  = 1'b0;
    repeat (4) @(negedge clk_in1);
    reset = 1'b0;
    repeat (4) @(negedge clk_in1);

    csLow();
    sendCmd(8'h9F);
    expectByte(8'hEF); expectByte(8'h40); expectByte(8'h16); expectByte(8'h00);
    csHigh();

    repeat (20) @(negedge clk_in1);
    checkOutput("byte_queue_left", byteQ.size(), 32'd0);
    checkOutput("cmd_queue_left", cmdQ.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
